fdivsqrt_resbuf: RTL and testbench
==================================

// Module: fdivsqrt_resbuf
// PURPOSE
//  Result buffer directly downstream of the combined div/rem/sqrt unit. Captures each completed
//  operation (UmM, UeM, DivStickyM, integer result, tag) on the done pulse and holds it in a
//  small in-order FIFO until the FPU/integer writeback port accepts it (valid/ready).
//  Decouples divider completion from writeback-port arbitration and applies backpressure when full.
// PARAMETERS
//  P      (none)  cvw_t configuration; supplies DIVb, NE, XLEN, FMTBITS
//  DEPTH  2       entries; any value >= 1, need not be a power of two
//  TAGW   5       destination register tag width
// PORTS
//  clk             in   1          clock
//  reset           in   1          synchronous, active-high reset
//  FDivDoneM       in   1          push: result inputs valid this cycle
//  UmM             in   DIVb+1     unrounded significand
//  UeM             in   NE+2       unrounded exponent
//  DivStickyM      in   1          sticky bit
//  FIntDivResultM  in   XLEN       integer quotient/remainder
//  IntDivM         in   1          1 = integer op, 0 = fp op
//  FmtM            in   FMTBITS    fp format
//  RdM             in   TAGW       destination tag
//  FlushBuf        in   1          discard all buffered entries (trap/redirect)
//  WbReady         in   1          writeback port accepts head entry
//  WbValid         out  1          head entry valid
//  WbUm, WbUe, WbSticky, WbIntRes, WbIntDiv, WbFmt, WbRd   out  (as inputs)  head entry fields
//  BufFull         out  1          count == DEPTH; divider FSM must not start a new op
//  BufOverflow     out  1          sticky error: push dropped while full with no pop
// BEHAVIOUR
//  - Clock clk; reset synchronous, active-high. Reset: head/tail pointers = 0, count = 0,
//    WbValid = 0, all Wb* data = 0, BufFull = 0, BufOverflow = 0. Reset mid-operation discards all.
//  - Push = FDivDoneM & ~FlushBuf. Pop = WbValid & WbReady & ~FlushBuf.
//  - Latency: push in cycle N -> WbValid = 1 in cycle N+1 (no same-cycle bypass).
//  - Outputs come from head entry; when count == 0, Wb* data driven to 0 (not stale).
//  - Full: push with pop in same cycle accepted (count unchanged); push without pop is dropped,
//    BufOverflow set and held until reset. Storage unchanged on drop.
//  - Empty: pop impossible (WbValid = 0); WbReady ignored.
//  - Pointers increment modulo DEPTH (explicit wrap at DEPTH-1 -> 0).
//  - count: +1 push only, -1 pop only, unchanged both/neither; range 0..DEPTH.
//  - FlushBuf: next cycle pointers = 0, count = 0, WbValid = 0; flush beats a simultaneous push
//    and pop (neither takes effect). BufOverflow not cleared by flush.
//  - Strict in-order: entries leave in push order; fields of an entry never mix across entries.
//  - BufFull is combinational from count (registered state), no input-to-output path.
// STRUCTURE
//  - Shared fpu package: typedef struct packed divres_t {Um, Ue, Sticky, IntRes, IntDiv, Fmt, Rd},
//    widths derived from P; constant DIVRES_W = $bits(divres_t).
//  - One sub-module: divres_ptr -- mod-DEPTH pointer counter with enable and sync clear,
//    instantiated for head and tail. Storage is a DEPTH x divres_t flop array written at tail.
// TESTING
//  1 Single op: FDivDoneM pulse cycle 10, UmM=0x1234, RdM=7, WbReady=1 -> WbValid=1 cycle 11 only,
//    WbUm=0x1234, WbRd=7; cycle 12 WbValid=0, Wb* = 0.
//  2 Fill/backpressure, DEPTH=2, WbReady=0: pushes Rd=1,2 -> BufFull=1; WbReady=1 -> pops Rd=1
//    then Rd=2 on consecutive cycles; BufFull=0 after first pop.
//  3 Full + simultaneous push/pop: full (Rd=1,2), push Rd=3 with WbReady=1 -> no overflow,
//    subsequent outputs Rd=2, Rd=3; BufOverflow=0.
//  4 Overflow: full, WbReady=0, push Rd=9 -> BufOverflow=1 stays; contents still Rd=1,2.
//  5 Flush: one entry buffered, FlushBuf=1 with FDivDoneM=1 and WbReady=1 -> next cycle
//    WbValid=0, count=0; next push Rd=4 appears normally one cycle later.
//  6 Wrap/reset: DEPTH=3, 7 push/pop cycles with random WbReady -> order preserved across wrap;
//    reset asserted with 2 entries -> next cycle all outputs 0.

Source files
------------

// File: rtl/fdivsqrt_resbuf_pkg.sv
// ============================================================================
//  Module      : fdivsqrt_resbuf_pkg
//  Description : Widths and the buffered result record for the div/sqrt
//                result buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fdivsqrt_resbuf_pkg;

    localparam int DIVB    = 23;
    localparam int NE      = 8;
    localparam int XLEN    = 32;
    localparam int FMTBITS = 2;
    localparam int RD_W    = 5;

    typedef struct packed {
        logic [DIVB:0]        Um;
        logic [NE+1:0]        Ue;
        logic                 Sticky;
        logic [XLEN-1:0]      IntRes;
        logic                 IntDiv;
        logic [FMTBITS-1:0]   Fmt;
        logic [RD_W-1:0]      Rd;
    } divres_t;

    localparam int DIVRES_W = $bits(divres_t);

endpackage

`default_nettype wire

// File: rtl/fdivsqrt_resbuf_ptr.sv
// ============================================================================
//  Module      : divres_ptr
//  Description : Modulo-DEPTH pointer with enable and synchronous clear.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module divres_ptr #(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [PTR_W-1:0] o_ptr
);

    logic [PTR_W-1:0] r_ptr;

    // Explicit wrap so non-power-of-two depths stay in range.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_ptr <= '0;
        end else if (i_en) begin
            if (r_ptr == PTR_W'(DEPTH - 1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= r_ptr + PTR_W'(1);
            end
        end
    end

    assign o_ptr = r_ptr;

endmodule

`default_nettype wire

// File: rtl/fdivsqrt_resbuf.sv
// ============================================================================
//  Module      : fdivsqrt_resbuf
//  Description : In-order result FIFO between the div/rem/sqrt unit and the
//                writeback port, with backpressure and sticky overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fdivsqrt_resbuf
    import fdivsqrt_resbuf_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int TAGW  = RD_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                FDivDoneM,
    input  logic [DIVB:0]       UmM,
    input  logic [NE+1:0]       UeM,
    input  logic                DivStickyM,
    input  logic [XLEN-1:0]     FIntDivResultM,
    input  logic                IntDivM,
    input  logic [FMTBITS-1:0]  FmtM,
    input  logic [TAGW-1:0]     RdM,
    input  logic                FlushBuf,
    input  logic                WbReady,
    output logic                WbValid,
    output logic [DIVB:0]       WbUm,
    output logic [NE+1:0]       WbUe,
    output logic                WbSticky,
    output logic [XLEN-1:0]     WbIntRes,
    output logic                WbIntDiv,
    output logic [FMTBITS-1:0]  WbFmt,
    output logic [TAGW-1:0]     WbRd,
    output logic                BufFull,
    output logic                BufOverflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] w_head;
    logic [PTR_W-1:0] w_tail;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;
    divres_t          r_mem [DEPTH];

    logic    w_valid, w_full, w_push, w_pop, w_wr, w_drop;
    divres_t w_in, w_head_ent;

    assign w_in = '{Um: UmM, Ue: UeM, Sticky: DivStickyM, IntRes: FIntDivResultM,
                    IntDiv: IntDivM, Fmt: FmtM, Rd: RdM};

    assign w_valid = (r_count != '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_push  = FDivDoneM & ~FlushBuf;
    assign w_pop   = w_valid & WbReady & ~FlushBuf;
    // A push into a full buffer only lands if the head leaves in the same cycle.
    assign w_wr    = w_push & (~w_full | w_pop);
    assign w_drop  = w_push & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
            if (FlushBuf) begin
                r_count <= '0;
            end else if (w_wr && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_wr) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (w_wr) begin
                r_mem[w_tail] <= w_in;
            end
        end
    end

    divres_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_head (
        .clk   (clk),
        .rst   (reset),
        .i_clr (FlushBuf),
        .i_en  (w_pop),
        .o_ptr (w_head)
    );

    divres_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_tail (
        .clk   (clk),
        .rst   (reset),
        .i_clr (FlushBuf),
        .i_en  (w_wr),
        .o_ptr (w_tail)
    );

    // Empty buffer presents zeros rather than stale storage.
    assign w_head_ent = w_valid ? r_mem[w_head] : '0;

    assign WbValid     = w_valid;
    assign WbUm        = w_head_ent.Um;
    assign WbUe        = w_head_ent.Ue;
    assign WbSticky    = w_head_ent.Sticky;
    assign WbIntRes    = w_head_ent.IntRes;
    assign WbIntDiv    = w_head_ent.IntDiv;
    assign WbFmt       = w_head_ent.Fmt;
    assign WbRd        = w_head_ent.Rd;
    assign BufFull     = w_full;
    assign BufOverflow = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_fdivsqrt_resbuf.sv
// ============================================================================
//  Module      : tb_fdivsqrt_resbuf
//  Description : Self-checking bench for fdivsqrt_resbuf (DEPTH 2 and 3).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fdivsqrt_resbuf;
    import fdivsqrt_resbuf_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic    reset, FDivDoneM, FlushBuf, WbReady;
    divres_t in_d;

    logic [DIVB:0]      um_a, um_b;
    logic [NE+1:0]      ue_a, ue_b;
    logic               st_a, st_b, id_a, id_b;
    logic [XLEN-1:0]    ir_a, ir_b;
    logic [FMTBITS-1:0] fm_a, fm_b;
    logic [RD_W-1:0]    rd_a, rd_b;
    logic               v_a, v_b, full_a, full_b, ovf_a, ovf_b;
    divres_t            out_a, out_b;

    assign out_a = {um_a, ue_a, st_a, ir_a, id_a, fm_a, rd_a};
    assign out_b = {um_b, ue_b, st_b, ir_b, id_b, fm_b, rd_b};

    fdivsqrt_resbuf #(.DEPTH(2), .TAGW(RD_W)) dut_a (
        .clk(clk), .reset(reset), .FDivDoneM(FDivDoneM),
        .UmM(in_d.Um), .UeM(in_d.Ue), .DivStickyM(in_d.Sticky),
        .FIntDivResultM(in_d.IntRes), .IntDivM(in_d.IntDiv), .FmtM(in_d.Fmt),
        .RdM(in_d.Rd), .FlushBuf(FlushBuf), .WbReady(WbReady),
        .WbValid(v_a), .WbUm(um_a), .WbUe(ue_a), .WbSticky(st_a),
        .WbIntRes(ir_a), .WbIntDiv(id_a), .WbFmt(fm_a), .WbRd(rd_a),
        .BufFull(full_a), .BufOverflow(ovf_a)
    );

    fdivsqrt_resbuf #(.DEPTH(3), .TAGW(RD_W)) dut_b (
        .clk(clk), .reset(reset), .FDivDoneM(FDivDoneM),
        .UmM(in_d.Um), .UeM(in_d.Ue), .DivStickyM(in_d.Sticky),
        .FIntDivResultM(in_d.IntRes), .IntDivM(in_d.IntDiv), .FmtM(in_d.Fmt),
        .RdM(in_d.Rd), .FlushBuf(FlushBuf), .WbReady(WbReady),
        .WbValid(v_b), .WbUm(um_b), .WbUe(ue_b), .WbSticky(st_b),
        .WbIntRes(ir_b), .WbIntDiv(id_b), .WbFmt(fm_b), .WbRd(rd_b),
        .BufFull(full_b), .BufOverflow(ovf_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DIVB:0] um_of(input logic [RD_W-1:0] rd);
        return (rd == 5'd7) ? 24'h001234 : (24'h00A000 | 24'(rd));
    endfunction

    function automatic divres_t fields(input logic [RD_W-1:0] rd);
        divres_t d;
        d.Um     = um_of(rd);
        d.Ue     = 10'(rd * 5 + 1);
        d.Sticky = rd[0];
        d.IntRes = 32'hC0DE0000 | 32'(rd);
        d.IntDiv = rd[1];
        d.Fmt    = rd[1:0];
        d.Rd     = rd;
        return d;
    endfunction

    task automatic drive(input bit rst, input bit done, input bit flush, input bit rdy, input divres_t d);
        reset     = rst;
        FDivDoneM = done;
        FlushBuf  = flush;
        WbReady   = rdy;
        in_d      = d;
    endtask

    // Directed vectors for the DEPTH=2 instance: inputs held for one cycle,
    // expected outputs are those visible during that same cycle.
    typedef struct {
        bit              rst, done, flush, rdy;
        logic [RD_W-1:0] rd;
        bit              ev;
        logic [RD_W-1:0] erd;
        bit              efull, eovf;
    } vec_t;

    function automatic vec_t V(input bit rst, input bit done, input bit flush, input bit rdy,
                               input logic [RD_W-1:0] rd, input bit ev,
                               input logic [RD_W-1:0] erd, input bit efull, input bit eovf);
        vec_t t;
        t.rst = rst; t.done = done; t.flush = flush; t.rdy = rdy; t.rd = rd;
        t.ev = ev; t.erd = erd; t.efull = efull; t.eovf = eovf;
        return t;
    endfunction

    localparam int NV = 32;
    vec_t tv [NV];

    // Reference model: per instance an ordered list, shifted on pop.
    divres_t mq   [2][0:3];
    int      mcnt [2];
    bit      movf [2];
    int      mdep [2];

    task automatic model_check(input string tag);
        divres_t exp_d, act_d;
        logic    act_v, act_f, act_o;
        for (int k = 0; k < 2; k++) begin
            exp_d = (mcnt[k] > 0) ? mq[k][0] : '0;
            act_d = (k == 0) ? out_a : out_b;
            act_v = (k == 0) ? v_a : v_b;
            act_f = (k == 0) ? full_a : full_b;
            act_o = (k == 0) ? ovf_a : ovf_b;
            check($sformatf("%s.d%0d.valid", tag, mdep[k]), 128'(act_v), 128'(mcnt[k] > 0));
            check($sformatf("%s.d%0d.data", tag, mdep[k]), 128'(act_d), 128'(exp_d));
            check($sformatf("%s.d%0d.full", tag, mdep[k]), 128'(act_f), 128'(mcnt[k] == mdep[k]));
            check($sformatf("%s.d%0d.ovf", tag, mdep[k]), 128'(act_o), 128'(movf[k]));
        end
    endtask

    task automatic model_update();
        bit pop;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                mcnt[k] = 0;
                movf[k] = 1'b0;
            end else if (FlushBuf) begin
                mcnt[k] = 0;
            end else begin
                pop = (mcnt[k] > 0) && WbReady;
                if (FDivDoneM && mcnt[k] == mdep[k] && !pop) begin
                    movf[k] = 1'b1;
                end else begin
                    if (pop) begin
                        for (int j = 0; j < 3; j++) mq[k][j] = mq[k][j+1];
                        mcnt[k]--;
                    end
                    if (FDivDoneM) begin
                        mq[k][mcnt[k]] = in_d;
                        mcnt[k]++;
                    end
                end
            end
        end
    endtask

    task automatic model_cycle(input string tag, input bit rst, input bit done, input bit flush,
                               input bit rdy, input divres_t d);
        drive(rst, done, flush, rdy, d);
        @(negedge clk);
        model_check(tag);
        model_update();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [95:0] rbits;
        mdep[0] = 2;
        mdep[1] = 3;
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0);

        //           rst  done fl rdy rd    ev erd   full ovf
        tv[0]  = V(1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 0);
        tv[1]  = V(0, 0, 0, 1, 5'd0, 0, 5'd0, 0, 0);
        tv[2]  = V(0, 1, 0, 1, 5'd7, 0, 5'd0, 0, 0);
        tv[3]  = V(0, 0, 0, 1, 5'd0, 1, 5'd7, 0, 0);
        tv[4]  = V(0, 0, 0, 1, 5'd0, 0, 5'd0, 0, 0);
        tv[5]  = V(0, 1, 0, 0, 5'd1, 0, 5'd0, 0, 0);
        tv[6]  = V(0, 1, 0, 0, 5'd2, 1, 5'd1, 0, 0);
        tv[7]  = V(0, 0, 0, 0, 5'd0, 1, 5'd1, 1, 0);
        tv[8]  = V(0, 0, 0, 1, 5'd0, 1, 5'd1, 1, 0);
        tv[9]  = V(0, 0, 0, 1, 5'd0, 1, 5'd2, 0, 0);
        tv[10] = V(0, 0, 0, 1, 5'd0, 0, 5'd0, 0, 0);
        tv[11] = V(0, 1, 0, 0, 5'd1, 0, 5'd0, 0, 0);
        tv[12] = V(0, 1, 0, 0, 5'd2, 1, 5'd1, 0, 0);
        tv[13] = V(0, 1, 0, 1, 5'd3, 1, 5'd1, 1, 0);
        tv[14] = V(0, 0, 0, 1, 5'd0, 1, 5'd2, 1, 0);
        tv[15] = V(0, 0, 0, 1, 5'd0, 1, 5'd3, 0, 0);
        tv[16] = V(0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 0);
        tv[17] = V(0, 1, 0, 0, 5'd1, 0, 5'd0, 0, 0);
        tv[18] = V(0, 1, 0, 0, 5'd2, 1, 5'd1, 0, 0);
        tv[19] = V(0, 1, 0, 0, 5'd9, 1, 5'd1, 1, 0);
        tv[20] = V(0, 0, 0, 0, 5'd0, 1, 5'd1, 1, 1);
        tv[21] = V(0, 0, 0, 1, 5'd0, 1, 5'd1, 1, 1);
        tv[22] = V(0, 0, 0, 1, 5'd0, 1, 5'd2, 0, 1);
        tv[23] = V(0, 0, 0, 1, 5'd0, 0, 5'd0, 0, 1);
        tv[24] = V(0, 1, 0, 0, 5'd5, 0, 5'd0, 0, 1);
        tv[25] = V(0, 1, 1, 1, 5'd6, 1, 5'd5, 0, 1);
        tv[26] = V(0, 1, 0, 0, 5'd4, 0, 5'd0, 0, 1);
        tv[27] = V(0, 0, 0, 1, 5'd0, 1, 5'd4, 0, 1);
        tv[28] = V(0, 0, 0, 1, 5'd0, 0, 5'd0, 0, 1);
        tv[29] = V(0, 1, 0, 0, 5'd8, 0, 5'd0, 0, 1);
        tv[30] = V(1, 1, 0, 0, 5'd10, 1, 5'd8, 0, 1);
        tv[31] = V(0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 0);

        for (int i = 0; i < NV; i++) begin
            drive(tv[i].rst, tv[i].done, tv[i].flush, tv[i].rdy, fields(tv[i].rd));
            @(negedge clk);
            if (i > 0) begin
                check($sformatf("vec%0d.valid", i), 128'(v_a), 128'(tv[i].ev));
                check($sformatf("vec%0d.rd", i), 128'(rd_a), 128'(tv[i].ev ? tv[i].erd : 5'd0));
                check($sformatf("vec%0d.um", i), 128'(um_a), 128'(tv[i].ev ? um_of(tv[i].erd) : 24'd0));
                check($sformatf("vec%0d.full", i), 128'(full_a), 128'(tv[i].efull));
                check($sformatf("vec%0d.ovf", i), 128'(ovf_a), 128'(tv[i].eovf));
            end
            @(posedge clk);
            #1;
        end

        // Resynchronise the model with both instances through a reset cycle.
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
        @(negedge clk);
        model_update();
        @(posedge clk);
        #1;

        // Back-to-back push/pop walks the DEPTH=3 pointers across the wrap.
        for (int i = 0; i < 7; i++) begin
            model_cycle("wrap", 1'b0, 1'b1, 1'b0, 1'b1, fields(5'(i + 11)));
        end

        for (int i = 0; i < 400; i++) begin
            rbits = {$urandom(), $urandom(), $urandom()};
            model_cycle("rand", $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 60,
                        $urandom_range(0, 99) < 5, $urandom_range(0, 1) == 1,
                        rbits[DIVRES_W-1:0]);
        end

        // Reset with two entries held in the DEPTH=3 buffer.
        model_cycle("rst2", 1'b1, 1'b0, 1'b0, 1'b0, '0);
        model_cycle("rst2", 1'b0, 1'b1, 1'b0, 1'b0, fields(5'd21));
        model_cycle("rst2", 1'b0, 1'b1, 1'b0, 1'b0, fields(5'd22));
        model_cycle("rst2", 1'b1, 1'b0, 1'b0, 1'b0, '0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
        @(negedge clk);
        check("rst2.after.valid", 128'(v_b), 128'(0));
        check("rst2.after.data", 128'(out_b), 128'(0));
        check("rst2.after.full", 128'(full_b), 128'(0));
        check("rst2.after.ovf", 128'(ovf_b), 128'(0));
        @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
